// File: rtl/nlc_sample_fifo.sv
// Sample buffer ahead of the ADC non-linearity correction engine: queues ADC
// samples and issues them one at a time. Optional drop counter: NLC_FIFO_DROP_CNT_EN.
module nlc_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adc_srdy,
  input  logic [20:0]   adc_x,
  output logic          nlc_srdyi,
  output logic [20:0]   nlc_x,
  input  logic          nlc_done,
  output logic [AW:0]   fifo_count,
  output logic          busy,
  output logic          overflow,
`ifdef NLC_FIFO_DROP_CNT_EN
  output logic [15:0]   drop_cnt,
`endif
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t        state;
  logic [20:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          push;
  logic          full;
  logic          drop;

  assign state_dbg = state;

  // A pop always coincides with entering ISSUE, so it frees a slot for a
  // same-cycle push even when the FIFO is full.
  always_comb begin
    full = (fifo_count == FULL_CNT);
    pop  = (fifo_count != '0) &&
           ((state == S_IDLE) || ((state == S_BUSY) && nlc_done));
    push = adc_srdy && (!full || pop);
    drop = adc_srdy && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= adc_x;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef NLC_FIFO_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  // nlc_x is only loaded on a pop, so it stays stable while the engine works.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      nlc_srdyi <= 1'b0;
      nlc_x     <= '0;
      busy      <= 1'b0;
    end else begin
      nlc_srdyi <= 1'b0;
      if (pop) begin
        nlc_x     <= mem[rd_ptr];
        nlc_srdyi <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (pop) begin
            state <= S_ISSUE;
            busy  <= 1'b1;
          end
        end
        S_ISSUE: begin
          state <= S_BUSY;
        end
        S_BUSY: begin
          if (nlc_done) begin
            if (pop) begin
              state <= S_ISSUE;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nlc_sample_fifo.sv
// Randomized bench for nlc_sample_fifo against a queue-based reference of the
// buffer and a simple engine responder that answers after a chosen latency.
module tb_nlc_sample_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          adc_srdy = 1'b0;
  logic [20:0]   adc_x = '0;
  logic          nlc_srdyi;
  logic [20:0]   nlc_x;
  wire           nlc_done;
  logic [AW:0]   fifo_count;
  logic          busy;
  logic          overflow;
  logic [15:0]   drop_cnt;
  logic [1:0]    state_dbg;

  logic eng_done = 1'b0;
  logic man_done = 1'b0;
  assign nlc_done = eng_done | man_done;

  nlc_sample_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .adc_srdy   (adc_srdy),
    .adc_x      (adc_x),
    .nlc_srdyi  (nlc_srdyi),
    .nlc_x      (nlc_x),
    .nlc_done   (nlc_done),
    .fifo_count (fifo_count),
    .busy       (busy),
    .overflow   (overflow),
`ifdef NLC_FIFO_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .state_dbg  (state_dbg)
  );

`ifndef NLC_FIFO_DROP_CNT_EN
  assign drop_cnt = '0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: exp_q is the buffer contents, the engine is either
  // holding a just-issued sample (m_issue) or working on one (m_wait)
  logic [20:0] exp_q[$];
  logic        m_issue = 1'b0;
  logic        m_wait  = 1'b0;
  logic [20:0] m_x     = '0;
  logic        m_ovf   = 1'b0;
  logic [15:0] m_drop  = '0;
  logic        take;

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_issue = 1'b0;
      m_wait  = 1'b0;
      m_x     = '0;
      m_ovf   = 1'b0;
      m_drop  = '0;
    end else begin
      take = (exp_q.size() > 0) && ((!m_issue && !m_wait) || (m_wait && nlc_done));
      if (take) m_x = exp_q.pop_front();
      if (adc_srdy) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(adc_x);
        else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
      end
      if (take) begin
        m_issue = 1'b1;
        m_wait  = 1'b0;
      end else if (m_issue) begin
        m_issue = 1'b0;
        m_wait  = 1'b1;
      end else if (m_wait && nlc_done) begin
        m_wait = 1'b0;
      end
    end
  end

  // per-cycle comparison of every output against the model
  int peak_count = 0;
  int issue_cnt  = 0;

  always @(negedge clk) begin
    check("srdyi", 32'(nlc_srdyi), 32'(m_issue));
    check("busy", 32'(busy), 32'(m_issue | m_wait));
    check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("nlc_x", 32'(nlc_x), 32'(m_x));
`ifdef NLC_FIFO_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    if (int'(fifo_count) > peak_count) peak_count = int'(fifo_count);
    if (nlc_srdyi === 1'b1) issue_cnt++;
  end

  // engine responder: done pulse eng_lat cycles after each issue
  int eng_lat   = 3;
  bit eng_stall = 1'b0;
  bit eng_rand  = 1'b0;
  int cd        = 0;

  always @(negedge clk) begin
    eng_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) eng_done = 1'b1;
    end
    if (nlc_srdyi === 1'b1 && !eng_stall) cd = eng_rand ? int'($urandom_range(1, 8)) : eng_lat;
  end

  // driver tasks
  task automatic strobe(input logic [20:0] x);
    @(negedge clk);
    adc_srdy = 1'b1;
    adc_x    = x;
    @(negedge clk);
    adc_srdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_srdyi", 32'(nlc_srdyi), 32'd0);

    // single sample: issue two edges after the strobe
    eng_lat = 40;
    strobe(21'h0ABCDE);
    @(negedge clk);
    check("lat_srdyi", 32'(nlc_srdyi), 32'd1);
    check("lat_x", 32'(nlc_x), 32'h0ABCDE);
    idle(50);
    check("single_busy", 32'(busy), 32'd0);
    check("single_count", 32'(fifo_count), 32'd0);

    // ordering with back-to-back strobes
    eng_lat = 30;
    peak_count = 0;
    @(negedge clk);
    for (int i = -1; i <= 3; i++) begin
      adc_srdy = 1'b1;
      adc_x    = 21'(i);
      @(negedge clk);
    end
    adc_srdy = 1'b0;
    idle(180);
    check("order_peak", 32'(peak_count), 32'd4);

    // overflow, with a push+pop at full before the dropped sample
    do_reset(1);
    eng_stall = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 9; i++) begin
      adc_srdy = 1'b1;
      adc_x    = 21'(32'h100 + i);
      @(negedge clk);
    end
    adc_srdy = 1'b0;
    idle(3);
    check("full_count", 32'(fifo_count), 32'd8);
    adc_srdy = 1'b1;
    adc_x    = 21'h1AA;
    man_done = 1'b1;
    @(negedge clk);
    adc_srdy = 1'b0;
    man_done = 1'b0;
    check("pushpop_count", 32'(fifo_count), 32'd8);
    check("pushpop_ovf", 32'(overflow), 32'd0);
    strobe(21'h1BB);
    check("drop_ovf", 32'(overflow), 32'd1);
`ifdef NLC_FIFO_DROP_CNT_EN
    check("drop_cnt1", 32'(drop_cnt), 32'd1);
`endif
    idle(3);
    eng_stall = 1'b0;
    eng_lat   = 3;
    man_done  = 1'b1;
    @(negedge clk);
    man_done  = 1'b0;
    idle(80);
    check("drain_count", 32'(fifo_count), 32'd0);

    // pointer wrap, no drops
    do_reset(1);
    base = issue_cnt;
    for (int i = 0; i < 20; i++) begin
      strobe(21'($urandom));
      idle(4);
    end
    idle(20);
    check("wrap_issues", 32'(issue_cnt - base), 32'd20);
    check("wrap_ovf", 32'(overflow), 32'd0);

    // reset while busy with entries queued
    eng_lat = 30;
    for (int i = 0; i < 4; i++) strobe(21'(32'h300 + i));
    idle(3);
    do_reset(1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    idle(40);
    eng_lat = 5;
    base = issue_cnt;
    strobe(21'h155555);
    idle(12);
    check("post_rst_issues", 32'(issue_cnt - base), 32'd1);

    // random traffic with random engine latency
    eng_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      adc_srdy = ($urandom_range(0, 2) == 0);
      adc_x    = 21'($urandom);
    end
    adc_srdy = 1'b0;
    idle(150);
    check("rand_drain", 32'(fifo_count), 32'd0);
    check("rand_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nlc_sample_fifo.md
# nlc_sample_fifo

Input buffering stage directly upstream of the ADC non-linearity correction engine. Captures ADC samples on every `adc_srdy` strobe into a circular FIFO. The correction engine is iterative and takes many cycles per sample, so this block issues samples to it one at a time. It holds each issued sample stable on the engine's `x_adc` input until the engine reports completion through its `srdyo`. Overflow is flagged, and can optionally be counted, so that lost samples are never silent.

## Interface
- `DEPTH`, default 8: FIFO entries. Must be a power of 2 and ≥ 2.
- `AW`, default 3: pointer width. Must equal log2(`DEPTH`).
- `clk` (in, 1): system clock. All logic is rising-edge.
- `reset` (in, 1): synchronous, active-high.
- `adc_srdy` (in, 1): ADC sample strobe, one cycle per sample.
- `adc_x` (in, 21): ADC sample, two's complement. Valid when `adc_srdy` = 1.
- `nlc_srdyi` (out, 1): one-cycle issue strobe. Connects to the engine's `srdyi`.
- `nlc_x` (out, 21): issued sample. Connects to the engine's `x_adc`.
- `nlc_done` (in, 1): engine completion. Connects to the engine's `srdyo`.
- `fifo_count` (out, AW+1): number of entries stored, from 0 to `DEPTH`.
- `busy` (out, 1): 1 while a sample is outstanding in the engine.
- `overflow` (out, 1): sticky. Set when a sample is dropped.
- `drop_cnt` (out, 16): dropped-sample count. Present only with `NLC_FIFO_DROP_CNT_EN`.

## Operation
- Storage: `DEPTH` × 21 register array, a write pointer and a read pointer (each `AW` bits, wrapping modulo `DEPTH`), and a registered count.
- Push: on `adc_srdy` = 1 with the FIFO not full, write `adc_x` at the write pointer and increment the pointer.
- Full push: `adc_srdy` = 1 with count = `DEPTH` and no pop in the same cycle.
  - The new sample is discarded and the stored contents are unchanged.
  - `overflow` is set to 1.
- Simultaneous push and pop when full: the push is accepted and the count stays at `DEPTH`. Overflow is not set.
- Simultaneous push and pop when empty: cannot occur, because a pop requires count > 0 at the start of the cycle.
- State machine (3 states):
  - **IDLE**: if count > 0, go to ISSUE. Otherwise stay in IDLE.
  - **ISSUE**:
    - Pop the head entry into the `nlc_x` register.
    - Assert `nlc_srdyi` for exactly this one cycle.
    - Go to BUSY.
  - **BUSY**:
    - On `nlc_done` = 1 with count > 0, go to ISSUE.
    - On `nlc_done` = 1 with count = 0, go to IDLE.
    - Otherwise stay in BUSY.
- `nlc_x` holds its value from ISSUE until the next ISSUE. The engine reads `x_adc` combinationally during conversion and section select, so `nlc_x` must not change while the sample is outstanding.
- `nlc_done` is ignored in IDLE and in ISSUE.
- `busy` = 1 in ISSUE and in BUSY.
- `overflow` clears only on reset.
- Reset mid-operation:
  - The FIFO is emptied, both pointers return to 0, and the state returns to IDLE.
  - The outstanding sample is abandoned. The engine shares the same reset.

## Timing
- All outputs are registered.
- Reset values: `nlc_srdyi` = 0, `nlc_x` = 0, `fifo_count` = 0, `busy` = 0, `overflow` = 0, `drop_cnt` = 0.
- `fifo_count` updates on the edge that performs the push or pop.
- Latency with an empty FIFO in IDLE:
  - `adc_srdy` sampled at edge E.
  - `nlc_srdyi` = 1 and `nlc_x` valid during the cycle after edge E+1.
- Back-to-back issue:
  - `nlc_done` sampled at edge D with count > 0.
  - Next `nlc_srdyi` high during the cycle after edge D.
- Minimum spacing between `nlc_srdyi` pulses: 2 cycles.
- Sustained input rate: any rate is accepted. Samples are lost only when the FIFO is full.

## Configuration
- Macro: `NLC_FIFO_DROP_CNT_EN`.
- Defined:
  - `drop_cnt` port exists.
  - `drop_cnt` increments on each discarded sample and saturates at 16'hFFFF.
  - Reset to 0.
- Undefined:
  - Port and counter are absent.
  - `overflow` still operates.

## Test plan
- Single sample: reset, then `adc_x` = 21'h0ABCDE with one strobe.
  - `nlc_srdyi` pulses once, 2 cycles later, with `nlc_x` = 21'h0ABCDE.
  - `busy` = 1 until `nlc_done` is pulsed 40 cycles later.
  - Then `busy` = 0 and `fifo_count` = 0.
- Ordering: strobe 5 samples -1, 0, 1, 2, 3 on consecutive cycles, with the engine answering 30 cycles after each issue.
  - Five issues in order -1, 0, 1, 2, 3.
  - `fifo_count` peaks at 4.
  - `nlc_x` is stable between each issue and its done.
- Overflow (`DEPTH` = 8): strobe 10 samples with the engine stalled.
  - The first sample is issued. Samples 2–9 fill the FIFO and `fifo_count` = 8.
  - Sample 10 is dropped: `overflow` = 1 and `drop_cnt` = 1 (macro on).
  - The issued sequence is samples 1–9.
- Push and pop at full: with the FIFO full, assert `nlc_done` so that ISSUE pops in the same cycle as a strobe.
  - The strobe is accepted, `fifo_count` stays at 8, and `overflow` stays 0.
- Pointer wrap: stream 20 samples with done returned 3 cycles after each issue.
  - All 20 are issued in order, with no drops, across 2+ pointer wraps.
- Reset mid-BUSY: with 3 entries queued and one outstanding, assert reset for 1 cycle.
  - All outputs take their reset values.
  - A later `nlc_done` with nothing issued is ignored.
  - A new strobe issues normally.
